sd_sector_reader: RTL and testbench
===================================

Name: sd_sector_reader

Overview:
- Hardware sequencer that reads one 512-byte SD card sector in SPI mode without CPU bit-banging.
- On `start` it issues CMD17, polls R1, waits for the data token, streams 512 data bytes into an external sector buffer, then discards the CRC.
- Sits beside the CPU-driven SD data/conf port. The top level muxes SD pins to this block while `busy`=1.
- A card-init sequence (CMD0/CMD8/ACMD41) stays in CPU firmware.

Parameters:
- R1_POLLS, 8: max 0xFF bytes sent while waiting for R1.
- TOKEN_POLLS, 4096: max 0xFF bytes sent while waiting for data token 0xFE.
- BLK_LEN, 512: data bytes per sector.

Ports:
- clk  in  1  system clock; SD SCLK = clk/2 while shifting.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- lba  in  32  sector number, latched on accepted start.
- sdhc  in  1  1: block addressing; 0: byte addressing. Latched with lba.
- busy  out  1  high from accepted start until done/err pulse.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on failure.
- err_code  out  3  valid while err=1 and held until next start.
  - 1: R1 timeout. 2: R1 nonzero. 3: token timeout. 4: error token.
- buf_we  out  1  sector buffer write strobe.
- buf_addr  out  9  byte index 0..BLK_LEN-1.
- buf_data  out  8  received byte.
- sd_miso  in  1  card DO.
- sd_mosi  out  1  card DI; idles 1.
- sd_sclk  out  1  SPI clock, mode 0; idles 0.
- sd_cs_n  out  1  card chip select, active low.

Behaviour:
- Reset values (immediate, also when reset hits mid-operation): sd_cs_n=1, sd_mosi=1, sd_sclk=0, busy=0, done=0, err=0, err_code=0, buf_we=0, buf_addr=0. FSM returns to IDLE; the partial transfer is abandoned with no done/err pulse.
- Byte engine (sub-module):
  - xfer(tx) takes exactly 16 clk.
  - MOSI is set MSB-first on SCLK low; MISO is sampled on the SCLK rising edge.
  - byte_done pulses in the 16th cycle with rx valid.
  - The next xfer may start in the cycle after byte_done.
- Command argument: arg = sdhc ? lba : (lba << 9), truncated to 32 bits.
- Command frame bytes: 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0xFF.
- FSM:
  - IDLE: start → busy=1, latch inputs, go to PRE. Start while busy is ignored.
  - PRE: cs_n=1, send one 0xFF, then assert cs_n=0 → CMD.
  - CMD: send the 6 frame bytes in order → R1.
  - R1: send 0xFF.
    - rx[7]=0 and rx=0x00 → TOKEN.
    - rx[7]=0 and rx≠0 → FAIL(2).
    - R1_POLLS bytes without rx[7]=0 → FAIL(1).
  - TOKEN: send 0xFF.
    - rx=0xFE → DATA.
    - rx[7:4]=0000 and rx≠0 → FAIL(4).
    - TOKEN_POLLS bytes of 0xFF → FAIL(3).
  - DATA: send 0xFF per byte; on each byte_done, buf_we=1 for one cycle with buf_addr=index and buf_data=rx. Index 0..BLK_LEN-1; after index BLK_LEN-1 → CRC.
  - CRC: two 0xFF bytes, rx discarded, no buf_we.
  - TAIL: cs_n=1, send one 0xFF (8 extra clocks) → IDLE with done=1 for one cycle.
  - FAIL(c): cs_n=1, one 0xFF byte → IDLE with err=1 for one cycle and err_code=c.
- busy drops in the same cycle done or err pulses.
- Counters: poll counters reset on state entry; the data index counter is 9 bits and saturates (no wrap).
- sd_sclk toggles only during xfer; it is held 0 between bytes and in IDLE.

Decomposition:
- Shared package sd_pkg:
  - state enum (IDLE, PRE, CMD, R1, TOKEN, DATA, CRC, TAIL, FAIL)
  - err_code constants
  - CMD17 = 0x51, TOKEN_START = 0xFE, FILL = 0xFF
- One sub-module, sd_spi_byte: 16-clk byte shifter with start/tx/rx/byte_done; owns sd_sclk, sd_mosi and MISO sampling. The top-level FSM owns sd_cs_n and the counters.

Test Plan:
- Card model, sdhc=1, lba=0x00000005: CMD bytes 51 00 00 00 05 FF. R1=0x00 on 2nd poll, token after 3 polls, data byte i=(i&0xFF) → 512 buf_we writes, addr 0..511, data matches. Done pulses once; busy falls the same cycle; cs_n=1 at end.
- sdhc=0, lba=0x00000003: argument bytes 00 00 06 00.
- Card never drives MISO low (all 0xFF): after 8 R1 polls → err=1, err_code=1, no buf_we, cs_n=1, busy=0.
- R1=0x04: err_code=2. Error token 0x08 returned during TOKEN phase: err_code=4, zero buf writes.
- Reset asserted at data byte 100: next clk sd_cs_n=1, sd_sclk=0, busy=0, no done/err. A new start then reads a full sector correctly.
- start pulsed again while busy: ignored; exactly one done and 512 writes.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD single-sector SPI reader.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_CMD   = 4'd2,
        ST_R1    = 4'd3,
        ST_TOKEN = 4'd4,
        ST_DATA  = 4'd5,
        ST_CRC   = 4'd6,
        ST_TAIL  = 4'd7,
        ST_FAIL  = 4'd8
    } sd_state_e;

    localparam logic [2:0] ERR_NONE          = 3'd0;
    localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd1;
    localparam logic [2:0] ERR_R1_NONZERO    = 3'd2;
    localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_TOKEN         = 3'd4;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] FILL        = 8'hFF;

    // Card address: block index for SDHC, byte offset (lba*512) for SDSC.
    function automatic logic [31:0] cmd_arg(input logic [31:0] lba, input logic sdhc);
        logic [31:0] arg;
        if (sdhc) begin
            arg = lba;
        end else begin
            arg = {lba[22:0], 9'd0};
        end
        return arg;
    endfunction

    // Byte idx of the CMD17 frame; CRC byte is a dummy since SPI mode ignores it.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] arg);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD17;
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = FILL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// 16-clock SPI mode-0 byte shifter: SCLK = clk/2, MOSI MSB-first, MISO
// captured on the clk edge that raises SCLK.
module sd_spi_byte (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       sd_miso,
    output logic [7:0] rx,
    output logic       byte_done,
    output logic       sd_sclk,
    output logic       sd_mosi
);

    logic       active_r;
    logic [3:0] cnt_r;
    logic [7:0] sh_r;
    logic [7:0] rx_r;
    logic       sclk_r;
    logic       mosi_r;
    logic       done_r;

    // Shift engine: even phases raise SCLK and sample, odd phases lower SCLK and present the next bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r <= 1'b0;
            cnt_r    <= 4'd0;
            sh_r     <= 8'hFF;
            rx_r     <= 8'h00;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= 4'd0;
            sclk_r   <= 1'b0;
            mosi_r   <= tx[7];
            sh_r     <= {tx[6:0], 1'b1};
            done_r   <= 1'b0;
        end else if (active_r) begin
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r[0] == 1'b0) begin
                sclk_r <= 1'b1;
                rx_r   <= {rx_r[6:0], sd_miso};
                done_r <= (cnt_r == 4'd14);
            end else if (cnt_r == 4'd15) begin
                active_r <= 1'b0;
                sclk_r   <= 1'b0;
                mosi_r   <= 1'b1;
                done_r   <= 1'b0;
            end else begin
                sclk_r <= 1'b0;
                mosi_r <= sh_r[7];
                sh_r   <= {sh_r[6:0], 1'b1};
                done_r <= 1'b0;
            end
        end else begin
            sclk_r <= 1'b0;
            mosi_r <= 1'b1;
            done_r <= 1'b0;
        end
    end

    assign rx        = rx_r;
    assign byte_done = done_r;
    assign sd_sclk   = sclk_r;
    assign sd_mosi   = mosi_r;

endmodule

// File: rtl/sd_sector_reader.sv
// CMD17 single-sector reader: frame, R1 poll, token wait, 512-byte stream
// into the sector buffer, CRC discard, then a trailing clock byte.
module sd_sector_reader
    import sd_pkg::*;
#(
    parameter int R1_POLLS    = 8,
    parameter int TOKEN_POLLS = 4096,
    parameter int BLK_LEN     = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] lba,
    input  logic        sdhc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_data,
    input  logic        sd_miso,
    output logic        sd_mosi,
    output logic        sd_sclk,
    output logic        sd_cs_n
);

    localparam logic [12:0] R1_LAST    = 13'(R1_POLLS - 1);
    localparam logic [12:0] TOKEN_LAST = 13'(TOKEN_POLLS - 1);
    localparam logic [8:0]  IDX_LAST   = 9'(BLK_LEN - 1);

    sd_state_e   state_r, nxt_state_s;
    logic [2:0]  byte_cnt_r, nxt_byte_cnt_s;
    logic [12:0] poll_cnt_r, nxt_poll_s;
    logic [8:0]  idx_r, nxt_idx_s;
    logic [2:0]  fail_code_r, nxt_fail_s;
    logic [31:0] arg_r;
    logic        kick_r;
    logic        cs_n_r, nxt_cs_n_s;
    logic        busy_r, done_r, err_r, buf_we_r;
    logic [2:0]  err_code_r;
    logic [8:0]  buf_addr_r;
    logic [7:0]  buf_data_r;
    logic        accept_s, xfer_start_s, wr_s, set_done_s, set_err_s;
    logic [7:0]  tx_s, rx_s;
    logic        byte_done_s;

    sd_spi_byte u_byte (
        .clk       (clk),
        .reset     (reset),
        .start     (xfer_start_s),
        .tx        (tx_s),
        .sd_miso   (sd_miso),
        .rx        (rx_s),
        .byte_done (byte_done_s),
        .sd_sclk   (sd_sclk),
        .sd_mosi   (sd_mosi)
    );

    // Next-state logic: each byte_done decides the next state and chains the next byte back-to-back.
    always_comb begin
        nxt_state_s    = state_r;
        nxt_byte_cnt_s = byte_cnt_r;
        nxt_poll_s     = poll_cnt_r;
        nxt_idx_s      = idx_r;
        nxt_fail_s     = fail_code_r;
        accept_s       = 1'b0;
        xfer_start_s   = 1'b0;
        wr_s           = 1'b0;
        set_done_s     = 1'b0;
        set_err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    nxt_state_s = ST_PRE;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_PRE: begin
                if (kick_r) begin
                    xfer_start_s = 1'b1;
                end else if (byte_done_s) begin
                    xfer_start_s   = 1'b1;
                    nxt_state_s    = ST_CMD;
                    nxt_byte_cnt_s = 3'd0;
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_CMD: begin
                if (byte_done_s) begin
                    xfer_start_s = 1'b1;
                    if (byte_cnt_r == 3'd5) begin
                        nxt_state_s = ST_R1;
                        nxt_poll_s  = 13'd0;
                    end else begin
                        nxt_byte_cnt_s = byte_cnt_r + 3'd1;
                    end
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_R1: begin
                if (byte_done_s) begin
                    xfer_start_s = 1'b1;
                    if (rx_s[7] == 1'b0) begin
                        if (rx_s == 8'h00) begin
                            nxt_state_s = ST_TOKEN;
                            nxt_poll_s  = 13'd0;
                        end else begin
                            nxt_state_s = ST_FAIL;
                            nxt_fail_s  = ERR_R1_NONZERO;
                        end
                    end else if (poll_cnt_r == R1_LAST) begin
                        nxt_state_s = ST_FAIL;
                        nxt_fail_s  = ERR_R1_TIMEOUT;
                    end else begin
                        nxt_poll_s = poll_cnt_r + 13'd1;
                    end
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_TOKEN: begin
                if (byte_done_s) begin
                    xfer_start_s = 1'b1;
                    if (rx_s == TOKEN_START) begin
                        nxt_state_s = ST_DATA;
                        nxt_idx_s   = 9'd0;
                    end else if ((rx_s[7:4] == 4'h0) && (rx_s != 8'h00)) begin
                        nxt_state_s = ST_FAIL;
                        nxt_fail_s  = ERR_TOKEN;
                    end else if (poll_cnt_r == TOKEN_LAST) begin
                        nxt_state_s = ST_FAIL;
                        nxt_fail_s  = ERR_TOKEN_TIMEOUT;
                    end else begin
                        nxt_poll_s = poll_cnt_r + 13'd1;
                    end
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (byte_done_s) begin
                    xfer_start_s = 1'b1;
                    wr_s         = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        nxt_state_s    = ST_CRC;
                        nxt_byte_cnt_s = 3'd0;
                    end else begin
                        nxt_idx_s = idx_r + 9'd1;
                    end
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_CRC: begin
                if (byte_done_s) begin
                    xfer_start_s = 1'b1;
                    if (byte_cnt_r == 3'd1) begin
                        nxt_state_s = ST_TAIL;
                    end else begin
                        nxt_byte_cnt_s = byte_cnt_r + 3'd1;
                    end
                end else begin
                    xfer_start_s = 1'b0;
                end
            end
            ST_TAIL: begin
                if (byte_done_s) begin
                    nxt_state_s = ST_IDLE;
                    set_done_s  = 1'b1;
                end else begin
                    set_done_s = 1'b0;
                end
            end
            ST_FAIL: begin
                if (byte_done_s) begin
                    nxt_state_s = ST_IDLE;
                    set_err_s   = 1'b1;
                end else begin
                    set_err_s = 1'b0;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
        // Card is selected only from the first CMD byte through the last CRC byte.
        case (nxt_state_s)
            ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC: nxt_cs_n_s = 1'b0;
            default:                                  nxt_cs_n_s = 1'b1;
        endcase
        if (nxt_state_s == ST_CMD) begin
            tx_s = frame_byte(nxt_byte_cnt_s, arg_r);
        end else begin
            tx_s = FILL;
        end
    end

    // State, counters and latched command argument.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 3'd0;
            poll_cnt_r  <= 13'd0;
            idx_r       <= 9'd0;
            fail_code_r <= ERR_NONE;
            kick_r      <= 1'b0;
            arg_r       <= 32'd0;
        end else begin
            state_r     <= nxt_state_s;
            byte_cnt_r  <= nxt_byte_cnt_s;
            poll_cnt_r  <= nxt_poll_s;
            idx_r       <= nxt_idx_s;
            fail_code_r <= nxt_fail_s;
            kick_r      <= accept_s;
            if (accept_s) begin
                arg_r <= cmd_arg(lba, sdhc);
            end
        end
    end

    // Registered status, chip select and sector-buffer write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_r     <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            buf_we_r   <= 1'b0;
            buf_addr_r <= 9'd0;
            buf_data_r <= 8'h00;
        end else begin
            cs_n_r   <= nxt_cs_n_s;
            done_r   <= set_done_s;
            err_r    <= set_err_s;
            buf_we_r <= wr_s;
            if (accept_s) begin
                busy_r     <= 1'b1;
                err_code_r <= ERR_NONE;
            end else if (set_done_s || set_err_s) begin
                busy_r <= 1'b0;
                if (set_err_s) begin
                    err_code_r <= fail_code_r;
                end
            end
            if (wr_s) begin
                buf_addr_r <= idx_r;
                buf_data_r <= rx_s;
            end
        end
    end

    assign sd_cs_n  = cs_n_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;
    assign buf_we   = buf_we_r;
    assign buf_addr = buf_addr_r;
    assign buf_data = buf_data_r;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: SPI card model driven from a scripted response
// stream, outcome predicted from the protocol rules.
module tb_sd_sector_reader;

    localparam int R1_POLLS    = 8;
    localparam int TOKEN_POLLS = 4096;
    localparam int BLK_LEN     = 512;
    localparam int LIMIT       = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] lba = 32'd0;
    logic        sdhc = 1'b0;
    logic        busy, done, err, buf_we;
    logic [2:0]  err_code;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        sd_miso, sd_mosi, sd_sclk, sd_cs_n;

    sd_sector_reader #(.R1_POLLS(R1_POLLS), .TOKEN_POLLS(TOKEN_POLLS), .BLK_LEN(BLK_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .lba(lba), .sdhc(sdhc),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .sd_miso(sd_miso), .sd_mosi(sd_mosi), .sd_sclk(sd_sclk), .sd_cs_n(sd_cs_n)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Scripted card reply: byte k is returned during host byte 6+k (after the CMD frame).
    logic [7:0] resp_mem [0:1023];
    int         resp_len = 0;

    function automatic logic [7:0] resp_at(input int i);
        if (i >= 0 && i < resp_len) return resp_mem[i];
        else return 8'hFF;
    endfunction

    // ---------------- card model (mode 0, shifts on SCLK fall) ----------------
    logic       miso_r = 1'b1;
    logic       prev_sclk = 1'b0;
    int         bits = 0;
    int         host_n = 0;
    logic [7:0] shin = 8'h00;
    logic [7:0] cur = 8'hFF;
    logic [7:0] nxt = 8'hFF;
    logic [7:0] host_mem [0:15];

    assign sd_miso = miso_r;

    always @(negedge clk) begin
        prev_sclk <= sd_sclk;
        if (sd_cs_n !== 1'b0) begin
            bits   <= 0;
            host_n <= 0;
            cur    <= 8'hFF;
            nxt    <= 8'hFF;
            miso_r <= 1'b1;
        end else if (sd_sclk && !prev_sclk) begin
            shin <= {shin[6:0], sd_mosi};
            bits <= bits + 1;
            if (bits == 7) begin
                if (host_n < 16) host_mem[host_n] <= {shin[6:0], sd_mosi};
                host_n <= host_n + 1;
                nxt    <= resp_at(host_n - 5);
            end
        end else if (!sd_sclk && prev_sclk) begin
            if (bits == 8) begin
                cur    <= nxt;
                bits   <= 0;
                miso_r <= nxt[7];
            end else begin
                miso_r <= cur[3'(7 - bits)];
            end
        end
    end

    // ---------------- output monitor ----------------
    logic       clr = 1'b0;
    int         wr_cnt = 0, addr_bad = 0, done_cnt = 0, err_cnt = 0, busy_bad = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] wr_data [0:BLK_LEN-1];

    always @(posedge clk) begin
        prev_busy <= busy;
        if (clr) begin
            wr_cnt <= 0; addr_bad <= 0; done_cnt <= 0; err_cnt <= 0; busy_bad <= 0;
        end else begin
            if (buf_we === 1'b1) begin
                if (buf_addr !== 9'(wr_cnt)) addr_bad <= addr_bad + 1;
                if (wr_cnt < BLK_LEN) wr_data[wr_cnt] <= buf_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (done === 1'b1) begin
                done_cnt <= done_cnt + 1;
                if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad <= busy_bad + 1;
            end
            if (err === 1'b1) begin
                err_cnt <= err_cnt + 1;
                if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad <= busy_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the reply stream with the R1/token rules.
    function automatic void predict(output int code, output int ds);
        int         p;
        bit         found;
        logic [7:0] b;
        p = 0; found = 1'b0; code = 0;
        for (int k = 0; k < R1_POLLS; k++) begin
            b = resp_at(p); p++;
            if (b[7] == 1'b0) begin
                found = 1'b1;
                if (b != 8'h00) code = 2;
                break;
            end
        end
        if (!found) code = 1;
        if (code == 0) begin
            found = 1'b0;
            for (int k = 0; k < TOKEN_POLLS; k++) begin
                b = resp_at(p); p++;
                if (b == 8'hFE) begin found = 1'b1; break; end
                if (b[7:4] == 4'h0 && b != 8'h00) begin found = 1'b1; code = 4; break; end
            end
            if (!found) code = 3;
        end
        ds = p;
    endfunction

    task automatic set_resp(input int r1_delay, input logic [7:0] r1, input int tok_delay,
                            input logic [7:0] tok, input bit ramp);
        int n;
        n = 0;
        for (int i = 0; i < r1_delay; i++) begin resp_mem[n] = 8'hFF; n++; end
        resp_mem[n] = r1; n++;
        for (int i = 0; i < tok_delay; i++) begin resp_mem[n] = 8'hFF; n++; end
        resp_mem[n] = tok; n++;
        for (int i = 0; i < BLK_LEN + 2; i++) begin
            resp_mem[n] = ramp ? 8'(i) : 8'($urandom_range(255, 0));
            n++;
        end
        resp_len = n;
    endtask

    task automatic clear_mon();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run_read(input string tag, input logic [31:0] a, input logic s, input int restart_at);
        int          code, ds;
        bit          ended;
        logic [31:0] arg;
        logic [7:0]  fr [0:5];
        predict(code, ds);
        arg = s ? a : a * 32'd512;
        fr[0] = 8'h51; fr[1] = arg[31:24]; fr[2] = arg[23:16];
        fr[3] = arg[15:8]; fr[4] = arg[7:0]; fr[5] = 8'hFF;
        clear_mon();
        lba = a; sdhc = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lba = $urandom; sdhc = ~s;
        check({tag, "_busy_rise"}, busy, 1);
        ended = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin ended = 1'b1; break; end
            start = (c == restart_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, "_finished"}, ended, 1);
        check({tag, "_done"}, done, (code == 0) ? 1 : 0);
        check({tag, "_err"}, err, (code != 0) ? 1 : 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_cs_end"}, sd_cs_n, 1);
        if (code != 0) check({tag, "_err_code"}, err_code, code);
        repeat (40) @(negedge clk);
        check({tag, "_sclk_idle"}, sd_sclk, 0);
        check({tag, "_mosi_idle"}, sd_mosi, 1);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_done_cnt"}, done_cnt, (code == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, err_cnt, (code != 0) ? 1 : 0);
        check({tag, "_busy_align"}, busy_bad, 0);
        check({tag, "_wr_cnt"}, wr_cnt, (code == 0) ? BLK_LEN : 0);
        check({tag, "_addr_seq"}, addr_bad, 0);
        if (code != 0) check({tag, "_err_code_held"}, err_code, code);
        for (int k = 0; k < 6; k++) check($sformatf("%s_cmd%0d", tag, k), host_mem[k], fr[k]);
        if (code == 0) begin
            for (int i = 0; i < BLK_LEN; i++)
                check($sformatf("%s_data%0d", tag, i), wr_data[i], resp_at(ds + i));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs_n", sd_cs_n, 1);
        check("rst_mosi", sd_mosi, 1);
        check("rst_sclk", sd_sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_buf_addr", buf_addr, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // SDHC block addressing, ramp data.
        set_resp(1, 8'h00, 3, 8'hFE, 1'b1);
        run_read("sdhc", 32'h0000_0005, 1'b1, -1);

        // SDSC byte addressing, random data.
        set_resp(0, 8'h00, 0, 8'hFE, 1'b0);
        run_read("sdsc", 32'h0000_0003, 1'b0, -1);

        // Card silent: R1 timeout.
        resp_len = 0;
        run_read("r1_to", 32'h0000_0010, 1'b1, -1);

        // R1 with an error flag.
        set_resp(0, 8'h04, 0, 8'hFE, 1'b0);
        run_read("r1_bad", 32'h0000_0020, 1'b1, -1);

        // Data error token.
        set_resp(0, 8'h00, 1, 8'h08, 1'b0);
        run_read("tok_err", 32'h0000_0030, 1'b0, -1);

        // Reset in the middle of the data phase.
        begin
            bit hit;
            set_resp(0, 8'h00, 2, 8'hFE, 1'b0);
            clear_mon();
            lba = 32'h0000_0040; sdhc = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hit = 1'b0;
            for (int c = 0; c < LIMIT; c++) begin
                @(negedge clk);
                if (buf_we === 1'b1 && buf_addr === 9'd100) begin hit = 1'b1; break; end
            end
            check("abort_reached", hit, 1);
            reset = 1'b1;
            @(negedge clk);
            check("abort_cs_n", sd_cs_n, 1);
            check("abort_sclk", sd_sclk, 0);
            check("abort_busy", busy, 0);
            check("abort_buf_we", buf_we, 0);
            check("abort_buf_addr", buf_addr, 0);
            reset = 1'b0;
            repeat (200) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            check("abort_no_err", err_cnt, 0);
            check("abort_idle_busy", busy, 0);
        end

        // Fresh read after the abort, randomized address and latencies.
        set_resp($urandom_range(6, 0), 8'h00, $urandom_range(10, 0), 8'hFE, 1'b0);
        run_read("post_abort", $urandom, 1'($urandom_range(1, 0)), -1);

        // Second start while busy must be ignored.
        set_resp(2, 8'h00, 1, 8'hFE, 1'b0);
        run_read("restart", 32'h0012_3456, 1'b0, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
